gearbox_32_24: RTL and testbench

- Width converter from a 32-bit word stream to a 24-bit word stream, little-endian byte order, framed by a last marker.
- Counterpart of the 24->32 gearbox. It sits on the transmit side, feeding 24-bit consumers from 32-bit producers.
- Every 3 input words produce 4 output words. A non-multiple frame tail is flushed at frame end.

---
 rtl/gearbox_32_24.sv | 134 +++++++++++++
 tb/tb_gearbox_32_24.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_32_24.sv
// 32-bit to 24-bit little-endian gearbox with frame-last handling.
// Optional GB_LAST_PAD_EN: emit a 1/2-byte frame tail as a PAD_BYTE-filled word instead of discarding it.
module gearbox_32_24 #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_en,
  input  logic        data_in_last,
  output logic        in_ready,
  output logic [23:0] data_out,
  output logic        data_out_en,
  output logic        data_out_last,
  output logic        drop_err
);

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        started_q;
  logic [23:0] data_out_q, data_out_d;
  logic        data_out_en_q, data_out_en_d;
  logic        data_out_last_q, data_out_last_d;
  logic        drop_err_q, drop_err_d;

  logic        pop_full;
  logic [3:0]  avail;
  logic        push;
`ifdef GB_LAST_PAD_EN
  logic [23:0] tail_word;
`endif

  // Bytes left in the buffer after this cycle's pop; a new word lands here.
  assign pop_full = (cnt_q >= 4'd3);
  assign avail    = pop_full ? (cnt_q - 4'd3) : cnt_q;
  assign in_ready = started_q && (state_q == ST_RUN) && (avail <= 4'd4);
  assign push     = data_en && in_ready;

`ifdef GB_LAST_PAD_EN
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      tail_word[i*8 +: 8] = (4'(i) < cnt_q) ? buf_q[i*8 +: 8] : PAD_BYTE;
    end
  end
`endif

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    cnt_d           = cnt_q;
    data_out_d      = data_out_q;
    data_out_en_d   = 1'b0;
    data_out_last_d = 1'b0;
    drop_err_d      = data_en && !in_ready;

    if (pop_full) begin
      data_out_d    = buf_q[23:0];
      data_out_en_d = 1'b1;
      buf_d         = buf_q >> 24;
      cnt_d         = avail;
      if (state_q == ST_DRAIN) begin
`ifdef GB_LAST_PAD_EN
        if (avail == 4'd0) begin
          data_out_last_d = 1'b1;
          state_d         = ST_RUN;
        end
`else
        // Last full word of the frame: any 1/2-byte remainder is dropped here.
        if (avail < 4'd3) begin
          data_out_last_d = 1'b1;
          state_d         = ST_RUN;
          cnt_d           = 4'd0;
          buf_d           = '0;
        end
`endif
      end
    end else if (state_q == ST_DRAIN) begin
`ifdef GB_LAST_PAD_EN
      if (cnt_q != 4'd0) begin
        data_out_d      = tail_word;
        data_out_en_d   = 1'b1;
        data_out_last_d = 1'b1;
      end
`endif
      cnt_d   = 4'd0;
      buf_d   = '0;
      state_d = ST_RUN;
    end

    // Pushes only happen in RUN, so they never collide with the DRAIN paths above.
    if (push) begin
      buf_d = buf_d | ({32'b0, data_in} << {avail, 3'b000});
      cnt_d = avail + 4'd4;
      if (data_in_last) state_d = ST_DRAIN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the byte buffer is reset as well so a
  // mid-frame reset cannot leak stale bytes into the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_RUN;
      buf_q           <= '0;
      cnt_q           <= '0;
      started_q       <= 1'b0;
      data_out_q      <= '0;
      data_out_en_q   <= 1'b0;
      data_out_last_q <= 1'b0;
      drop_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      buf_q           <= buf_d;
      cnt_q           <= cnt_d;
      started_q       <= 1'b1;
      data_out_q      <= data_out_d;
      data_out_en_q   <= data_out_en_d;
      data_out_last_q <= data_out_last_d;
      drop_err_q      <= drop_err_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_out_en   = data_out_en_q;
  assign data_out_last = data_out_last_q;
  assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_gearbox_32_24.sv
// Scoreboard bench for gearbox_32_24: directed frames push expected words, a negedge monitor compares.
// Expectations follow GB_LAST_PAD_EN the same way the design does.
module tb_gearbox_32_24;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_en = 1'b0;
  logic        data_in_last = 1'b0;
  logic        in_ready;
  logic [23:0] data_out;
  logic        data_out_en;
  logic        data_out_last;
  logic        drop_err;

  gearbox_32_24 #(.PAD_BYTE(8'h00)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_en      (data_en),
    .data_in_last (data_in_last),
    .in_ready     (in_ready),
    .data_out     (data_out),
    .data_out_en  (data_out_en),
    .data_out_last(data_out_last),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   drop_seen = 0;
  int   stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_exp(input logic [23:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every presented output word against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (drop_err) drop_seen++;
    if (data_out_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got %h last=%b with empty scoreboard", data_out, data_out_last);
      end else begin
        e = exp_q.pop_front();
        check("data_out", {8'h00, data_out}, {8'h00, e.data});
        check("data_out_last", {31'b0, data_out_last}, {31'b0, e.last});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send(input logic [31:0] d, input logic last);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
      stalls++;
    end
    if (!in_ready) check("send_timeout", 32'd1, 32'd0);
    data_en      = 1'b1;
    data_in      = d;
    data_in_last = last;
    @(negedge clk);
    data_en      = 1'b0;
    data_in_last = 1'b0;
  endtask

  task automatic drop_word();
    int w = 0;
    while (in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (in_ready) check("drop_wait_timeout", 32'd1, 32'd0);
    data_en      = 1'b1;
    data_in      = 32'hDEADBEEF;
    data_in_last = 1'b1;
    @(negedge clk);
    data_en      = 1'b0;
    data_in_last = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check(name, exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [7:0] b;
    logic [31:0] w;

    // Reset state
    #12;
    check("rst_data_out", {8'h00, data_out}, 32'h0);
    check("rst_out_en", {31'b0, data_out_en}, 32'd0);
    check("rst_out_last", {31'b0, data_out_last}, 32'd0);
    check("rst_drop_err", {31'b0, drop_err}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    check("in_ready_before_edge", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("in_ready_after_edge", {31'b0, in_ready}, 32'd1);

    // Three-word frame
    d0 = drop_seen;
    push_exp(24'h020100, 1'b0);
    push_exp(24'h050403, 1'b0);
    push_exp(24'h080706, 1'b0);
    push_exp(24'h0B0A09, 1'b1);
    send(32'h03020100, 1'b0);
    send(32'h07060504, 1'b0);
    send(32'h0B0A0908, 1'b1);
    wait_idle("t1_drain");
    check("t1_drops", drop_seen - d0, 32'd0);

    // Single-word frame, 1-byte tail
`ifdef GB_LAST_PAD_EN
    push_exp(24'h332211, 1'b0);
    push_exp(24'h000044, 1'b1);
`else
    push_exp(24'h332211, 1'b1);
`endif
    send(32'h44332211, 1'b1);
    wait_idle("t2_drain");

    // Two-word frame, 2-byte tail
    push_exp(24'h020100, 1'b0);
`ifdef GB_LAST_PAD_EN
    push_exp(24'h050403, 1'b0);
    push_exp(24'h000706, 1'b1);
`else
    push_exp(24'h050403, 1'b1);
`endif
    send(32'h03020100, 1'b0);
    send(32'h07060504, 1'b1);
    wait_idle("t3_drain");

    // Continuous 12-word frame: 16 outputs, 3 stall cycles
    for (int k = 0; k < 16; k++) begin
      b = 8'(3 * k);
      push_exp({b + 8'd2, b + 8'd1, b}, k == 15);
    end
    stalls = 0;
    d0 = drop_seen;
    for (int j = 0; j < 12; j++) begin
      b = 8'(4 * j);
      w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      send(w, j == 11);
    end
    check("t4_stalls", stalls, 32'd3);
    wait_idle("t4_drain");
    check("t4_drops", drop_seen - d0, 32'd0);

    // Drops while full in RUN and during DRAIN
    for (int k = 0; k < 8; k++) begin
      b = 8'h50 + 8'(3 * k);
      push_exp({b + 8'd2, b + 8'd1, b}, k == 7);
    end
    d0 = drop_seen;
    for (int j = 0; j < 5; j++) begin
      b = 8'h50 + 8'(4 * j);
      send({b + 8'd3, b + 8'd2, b + 8'd1, b}, 1'b0);
    end
    drop_word();
    send(32'h67666564, 1'b1);
    drop_word();
    wait_idle("t5_drain");
    check("t5_drops", drop_seen - d0, 32'd2);

    // Asynchronous reset mid-frame
    push_exp(24'h030201, 1'b0);
    send(32'h04030201, 1'b0);
    send(32'h08070605, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_data_out", {8'h00, data_out}, 32'h0);
    check("mid_rst_out_en", {31'b0, data_out_en}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_scoreboard", exp_q.size(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef GB_LAST_PAD_EN
    push_exp(24'hCCBBAA, 1'b0);
    push_exp(24'h0000DD, 1'b1);
`else
    push_exp(24'hCCBBAA, 1'b1);
`endif
    send(32'hDDCCBBAA, 1'b1);
    wait_idle("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
